// File: rtl/risc_spm_pkg.sv
// Shared types and constants for the RISC-SPM core: opcodes, FSM states, instruction field positions.
package risc_spm_pkg;

    localparam int WORD_W_DEF = 8;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int SRC_MSB = 3;
    localparam int SRC_LSB = 2;
    localparam int DST_MSB = 1;
    localparam int DST_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_NOT  = 4'h4,
        OP_RD   = 4'h5,
        OP_WR   = 4'h6,
        OP_BR   = 4'h7,
        OP_BRZ  = 4'h8,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
        S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
    } state_e;

endpackage

// File: rtl/risc_spm_alu.sv
// Combinational ALU: result = b op a (a is the Y operand or source register, b the destination register).
module risc_spm_alu
    import risc_spm_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  opcode_e           op,
    output logic [WORD_W-1:0] result,
    output logic              zero
);

    always_comb begin
        case (op)
            OP_ADD:  result = b + a;
            OP_SUB:  result = b - a;
            OP_AND:  result = b & a;
            OP_NOT:  result = ~a;
            default: result = b;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/risc_spm_core.sv
// RISC-SPM controller, register file and program counter driving an external unified memory.
// Optional `halted` status port enabled by defining RISC_SPM_HALT_PORT_EN.
module risc_spm_core
    import risc_spm_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_out,
    output logic [WORD_W-1:0] address,
    output logic [WORD_W-1:0] data_in,
`ifdef RISC_SPM_HALT_PORT_EN
    output logic              halted,
`endif
    output logic              write
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] y_q, y_d;
    logic [WORD_W-1:0] add_r_q, add_r_d;
    logic              z_q, z_d;
    logic [WORD_W-1:0] r_q [4];
    logic [WORD_W-1:0] r_d [4];
    logic              write_q, write_d;
    logic [WORD_W-1:0] data_in_q, data_in_d;
    logic              halted_q, halted_d;

    opcode_e           opcode;
    logic [1:0]        src, dst;
    logic [WORD_W-1:0] alu_a, alu_res;
    logic              alu_zero;

    assign opcode = opcode_e'(ir_q[OP_MSB:OP_LSB]);
    assign src    = ir_q[SRC_MSB:SRC_LSB];
    assign dst    = ir_q[DST_MSB:DST_LSB];

    // NOT executes in decode straight from the source register; two-operand ops use Y in EX1.
    assign alu_a = (state_q == S_EX1) ? y_q : r_q[src];

    risc_spm_alu #(.WORD_W(WORD_W)) u_alu (
        .a      (alu_a),
        .b      (r_q[dst]),
        .op     (opcode),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        y_d     = y_q;
        add_r_d = add_r_q;
        z_d     = z_q;
        for (int i = 0; i < 4; i++) r_d[i] = r_q[i];

        case (state_q)
            S_IDLE: state_d = S_FET1;
            S_FET1: begin
                add_r_d = pc_q;
                state_d = S_FET2;
            end
            S_FET2: begin
                ir_d    = data_out;
                pc_d    = pc_q + 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    OP_NOP: state_d = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        y_d     = r_q[src];
                        state_d = S_EX1;
                    end
                    OP_NOT: begin
                        r_d[dst] = alu_res;
                        z_d      = alu_zero;
                        state_d  = S_FET1;
                    end
                    OP_RD: begin
                        add_r_d = pc_q;
                        state_d = S_RD1;
                    end
                    OP_WR: begin
                        add_r_d = pc_q;
                        state_d = S_WR1;
                    end
                    OP_BR: begin
                        add_r_d = pc_q;
                        state_d = S_BR1;
                    end
                    OP_BRZ: begin
                        if (z_q) begin
                            add_r_d = pc_q;
                            state_d = S_BR1;
                        end else begin
                            pc_d    = pc_q + 1'b1;
                            state_d = S_FET1;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_EX1: begin
                r_d[dst] = alu_res;
                z_d      = alu_zero;
                state_d  = S_FET1;
            end
            S_RD1: begin
                add_r_d = data_out;
                pc_d    = pc_q + 1'b1;
                state_d = S_RD2;
            end
            S_RD2: begin
                r_d[dst] = data_out;
                state_d  = S_FET1;
            end
            S_WR1: begin
                add_r_d = data_out;
                pc_d    = pc_q + 1'b1;
                state_d = S_WR2;
            end
            S_WR2: state_d = S_FET1;
            S_BR1: begin
                add_r_d = data_out;
                state_d = S_BR2;
            end
            S_BR2: begin
                pc_d    = data_out;
                state_d = S_FET1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered off the next state so they line up exactly with S_WR2 / S_HALT.
        write_d   = (state_d == S_WR2);
        data_in_d = write_d ? r_q[src] : '0;
        halted_d  = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            y_q       <= '0;
            add_r_q   <= '0;
            z_q       <= 1'b0;
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
            write_q   <= 1'b0;
            data_in_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            y_q       <= y_d;
            add_r_q   <= add_r_d;
            z_q       <= z_d;
            for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
            write_q   <= write_d;
            data_in_q <= data_in_d;
            halted_q  <= halted_d;
        end
    end

    assign address = add_r_q;
    assign write   = write_q;
    assign data_in = data_in_q;
`ifdef RISC_SPM_HALT_PORT_EN
    assign halted  = halted_q;
`else
    logic unused_halted;
    assign unused_halted = halted_q;
`endif

endmodule

// File: tb/tb_risc_spm_core.sv
// Directed bench for risc_spm_core: runs a small program against a bench memory and checks the write trail.
module tb_risc_spm_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_out, address, data_in;
    logic       write;
`ifdef RISC_SPM_HALT_PORT_EN
    logic       halted;
`endif

    logic [7:0]   prog [256];
    logic [7:0]   wmem [256];
    logic [255:0] wvld;

    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         wr_cnt = 0;
    int         dbl_wr = 0;
    logic       prev_write = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    risc_spm_core dut (
        .clk      (clk),
        .rst      (rst),
        .data_out (data_out),
        .address  (address),
        .data_in  (data_in),
`ifdef RISC_SPM_HALT_PORT_EN
        .halted   (halted),
`endif
        .write    (write)
    );

    // Written locations shadow the program image.
    assign data_out = wvld[address] ? wmem[address] : prog[address];

    always @(posedge clk) begin
        if (rst) wvld <= '0;
        else if (write) begin
            wmem[address] <= data_in;
            wvld[address] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (write) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(data_in);
            wr_cnt = wr_cnt + 1;
            if (prev_write) dbl_wr = dbl_wr + 1;
        end
        prev_write = write;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_a [6];
    logic [7:0] exp_d [6];
    logic [7:0] hold_addr;
    int         addr_chg;
    int         wr_before;
    int         waited;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            prog[i] = 8'h00;
            wmem[i] = 8'h00;
        end
        // Main program: arithmetic, both BRZ outcomes, WR, readback, NOT, AND, indirect BR, HALT.
        prog[8'h00] = 8'h50; prog[8'h01] = 8'h80;   // RD R0,[80]
        prog[8'h02] = 8'h51; prog[8'h03] = 8'h81;   // RD R1,[81]
        prog[8'h04] = 8'h11;                         // ADD R0->R1
        prog[8'h05] = 8'h64; prog[8'h06] = 8'hC1;   // WR R1,[C1]
        prog[8'h07] = 8'h80; prog[8'h08] = 8'h90;   // BRZ (not taken)
        prog[8'h09] = 8'h25;                         // SUB R1,R1
        prog[8'h0A] = 8'h64; prog[8'h0B] = 8'hC2;   // WR R1,[C2]
        prog[8'h0C] = 8'h80; prog[8'h0D] = 8'h90;   // BRZ (taken) -> 20
        prog[8'h20] = 8'h52; prog[8'h21] = 8'h82;   // RD R2,[82]
        prog[8'h22] = 8'h68; prog[8'h23] = 8'hC0;   // WR R2,[C0]
        prog[8'h24] = 8'h53; prog[8'h25] = 8'hC0;   // RD R3,[C0]
        prog[8'h26] = 8'h4C;                         // NOT R3->R0
        prog[8'h27] = 8'h60; prog[8'h28] = 8'hC3;   // WR R0,[C3]
        prog[8'h29] = 8'h33;                         // AND R0->R3
        prog[8'h2A] = 8'h6C; prog[8'h2B] = 8'hC4;   // WR R3,[C4]
        prog[8'h2C] = 8'h70; prog[8'h2D] = 8'h91;   // BR -> 40
        prog[8'h40] = 8'h1A;                         // ADD R2,R2 (wraps)
        prog[8'h41] = 8'h68; prog[8'h42] = 8'hC5;   // WR R2,[C5]
        prog[8'h43] = 8'hF0;                         // HALT
        prog[8'h80] = 8'h05; prog[8'h81] = 8'h03; prog[8'h82] = 8'hA5;
        prog[8'h90] = 8'h20; prog[8'h91] = 8'h40;

        exp_a[0] = 8'hC1; exp_d[0] = 8'h08;
        exp_a[1] = 8'hC2; exp_d[1] = 8'h00;
        exp_a[2] = 8'hC0; exp_d[2] = 8'hA5;
        exp_a[3] = 8'hC3; exp_d[3] = 8'h5A;
        exp_a[4] = 8'hC4; exp_d[4] = 8'h00;
        exp_a[5] = 8'hC5; exp_d[5] = 8'h4A;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_address", address, 8'h00);
        chk("rst_write", write, 1'b0);
        rst = 1'b0;

        // IDLE, FET1, FET2 keep address at 00; DEC of the RD moves it to the operand at 01.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("fetch_addr_c3", address, 8'h00);
        @(negedge clk);
        chk("operand_addr_c4", address, 8'h01);
        @(negedge clk);
        chk("rd_target_c5", address, 8'h80);

        waited = 0;
        while (wr_cnt < 6 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 600) chk("wr_timeout", 1'b1, 1'b0);
        chk("wr_count", wr_cnt, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_addr_q.size()) begin
                chk($sformatf("wr%0d_addr", i), wr_addr_q[i], exp_a[i]);
                chk($sformatf("wr%0d_data", i), wr_data_q[i], exp_d[i]);
            end
        end
        chk("wr_single_cycle", dbl_wr, 0);
        chk("mem_c0", wmem[8'hC0], 8'hA5);

        repeat (10) @(negedge clk);
        hold_addr = address;
        chk("halt_address", hold_addr, 8'h43);
        addr_chg  = 0;
        wr_before = wr_cnt;
        repeat (25) begin
            @(negedge clk);
            if (address !== hold_addr) addr_chg++;
        end
        chk("halt_addr_frozen", addr_chg, 0);
        chk("halt_no_write", wr_cnt - wr_before, 0);
`ifdef RISC_SPM_HALT_PORT_EN
        chk("halted_hi", halted, 1'b1);
`endif

        // Abort a WR mid-instruction with reset, then run an illegal opcode.
        prog[8'h00] = 8'h60; prog[8'h01] = 8'hC6; prog[8'h02] = 8'hF0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
`ifdef RISC_SPM_HALT_PORT_EN
        chk("halted_rst", halted, 1'b0);
`endif
        rst = 1'b0;
        waited = 0;
        while (address !== 8'h01 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("wr1_reached", address, 8'h01);
        wr_before = wr_cnt;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_address", address, 8'h00);
        chk("abort_no_write", wr_cnt - wr_before, 0);

        prog[8'h00] = 8'hB0;
        rst = 1'b0;
        addr_chg = 0;
        repeat (30) begin
            @(negedge clk);
            if (address !== 8'h00) addr_chg++;
        end
        chk("illegal_addr_frozen", addr_chg, 0);
        chk("illegal_no_write", wr_cnt - wr_before, 0);
        chk("illegal_write_low", write, 1'b0);
`ifdef RISC_SPM_HALT_PORT_EN
        chk("illegal_halted", halted, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/risc_spm_core.md
Name: risc_spm_core

Overview:
- 8-bit stored-program machine (simple RISC, SPM) with four general registers R0–R3, a program counter and a single zero flag.
- Fetches, decodes and executes byte instructions from an external unified program/data memory, which sits outside the block.
- Exposes only a memory address, write data, a write strobe, and read data coming back from memory.

Parameters:
- WORD_W, 8, datapath, memory data and address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- data_out  input  WORD_W  read data from memory at `address`. Memory read is combinational (same cycle).
- address  output  WORD_W  memory address; equals internal Add_R.
- data_in  output  WORD_W  write data to memory.
- write  output  1  memory write strobe; memory captures `data_in` at `address` on the clk edge while high.

Behaviour:
- Instruction byte format: opcode [7:4], src [3:2], dest [1:0].
- Opcodes:
  - NOP 0
  - ADD 1
  - SUB 2
  - AND 3
  - NOT 4
  - RD 5
  - WR 6
  - BR 7
  - BRZ 8
  - HALT F
  - 9–E are treated as HALT.
- RD, WR, BR and BRZ are two-byte instructions; the second byte is an address.
- Reset (rst=1 at edge):
  - R0–R3, PC, IR, Y, Add_R and Z cleared to 0; state = S_IDLE.
  - Outputs: address=0, write=0, data_in=0.
  - Reset mid-instruction aborts it with no memory write.
- States and actions, one clock each:
  - S_IDLE: go to S_FET1.
  - S_FET1: Add_R<=PC → S_FET2.
  - S_FET2: IR<=data_out; PC<=PC+1 → S_DEC.
  - S_DEC:
    - NOP → S_FET1.
    - ADD/SUB/AND: Y<=R[src] → S_EX1.
    - NOT: R[dest]<=~R[src]; Z<=(result==0) → S_FET1.
    - RD/WR/BR: Add_R<=PC → S_RD1 / S_WR1 / S_BR1.
    - BRZ with Z=1: Add_R<=PC → S_BR1.
    - BRZ with Z=0: PC<=PC+1 (skip operand) → S_FET1.
    - HALT → S_HALT.
  - S_EX1: R[dest]<=ALU(Y, R[dest]); Z updated → S_FET1.
    - ADD: R[dest]+Y.
    - SUB: R[dest]−Y.
    - AND: R[dest]&Y.
  - S_RD1: Add_R<=data_out; PC<=PC+1 → S_RD2.
  - S_RD2: R[dest]<=data_out → S_FET1.
  - S_WR1: Add_R<=data_out; PC<=PC+1 → S_WR2.
  - S_WR2: write=1, data_in=R[src] → S_FET1.
  - S_BR1: Add_R<=data_out → S_BR2.
  - S_BR2: PC<=data_out → S_FET1. The branch is indirect: the target is the byte stored at the operand address.
  - S_HALT: stay until rst.
- Arithmetic:
  - Modulo 2^8: carry and borrow are discarded.
  - Z reflects only the last ADD/SUB/AND/NOT result; RD, WR and branches leave it unchanged.
- PC wraps FF→00.
- write is high only in S_WR2; data_in = R[src] in S_WR2, else 0.
- src==dest is legal, e.g. SUB R1,R1 → 0 and Z=1.

Optional Feature:
- Macro: RISC_SPM_HALT_PORT_EN.
- Defined: adds output port `halted` (1 bit), high exactly while state==S_HALT, 0 in reset.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Package risc_spm_pkg:
  - opcode enum (4 bits), state enum.
  - field-position constants for opcode/src/dest.
  - WORD_W default.
- One sub-module, risc_spm_alu:
  - Combinational: inputs a=Y, b=bus, op.
  - Outputs result and zero.
- Controller FSM and register file stay in risc_spm_core.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 2 cycles, release.
  - Response: address=00 and write=0; first fetch reads address 00 two cycles after release.
- ADD:
  - Stimulus: RD R0,[80] with mem[80]=05; RD R1,[81] with mem[81]=03; ADD src=R0,dest=R1.
  - Response: R1=08, Z=0.
- SUB to zero and BRZ taken:
  - Stimulus: SUB R1,R1 then BRZ [90] with mem[90]=20.
  - Response: Z=1; next fetch at address 20.
- BRZ not taken:
  - Stimulus: after a nonzero ADD, BRZ.
  - Response: PC skips the operand byte; fetch continues at the following instruction.
- WR:
  - Stimulus: R2=A5, WR R2,[C0].
  - Response: single-cycle write=1 with address=C0, data_in=A5; then mem[C0]=A5.
- HALT / illegal opcode:
  - Stimulus: opcode F (and separately B).
  - Response: FSM stays halted; address frozen and write=0 for 20+ cycles; `halted`=1 when RISC_SPM_HALT_PORT_EN is defined.
